// File: rtl/z16_instr_encoder_if.sv
// Handshake and memory-write bundle between a program front end and the Z16 instruction encoder.
// i_valid/o_ready: a beat transfers on a rising edge where both are high; o_ready depends only on registered state.
interface z16_instr_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              i_start;
    logic              i_valid;
    logic              o_ready;
    logic [3:0]        i_opcode;
    logic [3:0]        i_rd_addr;
    logic [3:0]        i_rs1_addr;
    logic [3:0]        i_rs2_addr;
    logic [15:0]       i_imm;
    logic              i_last;
    logic              o_mem_wen;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [15:0]       o_mem_wdata;
    logic [ADDR_W:0]   o_count;
    logic              o_busy;
    logic              o_done;
    logic              o_err_imm;
    logic              o_err_full;
    logic [1:0]        o_state;

    modport master (
        output i_start, i_valid, i_opcode, i_rd_addr, i_rs1_addr, i_rs2_addr, i_imm, i_last,
        input  o_ready, o_mem_wen, o_mem_addr, o_mem_wdata, o_count, o_busy, o_done,
               o_err_imm, o_err_full, o_state
    );

    modport slave (
        input  i_start, i_valid, i_opcode, i_rd_addr, i_rs1_addr, i_rs2_addr, i_imm, i_last,
        output o_ready, o_mem_wen, o_mem_addr, o_mem_wdata, o_count, o_busy, o_done,
               o_err_imm, o_err_full, o_state
    );
endinterface

// File: rtl/z16_instr_encoder.sv
// Packs instruction fields into 16-bit Z16 words and writes them to consecutive
// instruction-memory addresses, tracking session progress and encoding errors.
module z16_instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    z16_instr_encoder_if.slave     bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
    localparam logic [3:0]        OP_IMM  = 4'hA;

    logic [1:0]        state;
    logic [ADDR_W:0]   count;
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       wdata;
    logic              err_imm;
    logic              err_full;

    logic              ready;
    logic              accept;
    logic              is_imm;
    logic              imm_fits;
    logic [15:0]       word;
    logic [ADDR_W:0]   count_inc;

    assign ready     = (state == LOAD) && (count < DEPTH_C);
    assign accept    = bus.i_valid && ready;
    assign is_imm    = (bus.i_opcode == OP_IMM);
    // Sign bit and everything above it must agree for the value to fit in 4 bits.
    assign imm_fits  = (&bus.i_imm[15:3]) | ~(|bus.i_imm[15:3]);
    assign count_inc = count + 1'b1;
    assign word      = {(is_imm ? bus.i_imm[3:0] : bus.i_rs2_addr),
                        bus.i_rs1_addr, bus.i_rd_addr, bus.i_opcode};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            count    <= '0;
            wen      <= 1'b0;
            addr     <= '0;
            wdata    <= '0;
            err_imm  <= 1'b0;
            err_full <= 1'b0;
        end else begin
            wen <= accept;
            case (state)
                LOAD: begin
                    if (accept) begin
                        addr  <= BASE_C + count[ADDR_W-1:0];
                        wdata <= word;
                        count <= count_inc;
                        if (is_imm && !imm_fits) begin
                            err_imm <= 1'b1;
                        end
                        // i_last wins over a simultaneous fill, so an exact fill is not an error.
                        if (bus.i_last) begin
                            state <= DONE;
                        end else if (count_inc == DEPTH_C) begin
                            state    <= DONE;
                            err_full <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (bus.i_start) begin
                        state    <= LOAD;
                        count    <= '0;
                        err_imm  <= 1'b0;
                        err_full <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.o_ready     = ready;
    assign bus.o_mem_wen   = wen;
    assign bus.o_mem_addr  = addr;
    assign bus.o_mem_wdata = wdata;
    assign bus.o_count     = count;
    assign bus.o_busy      = (state == LOAD);
    assign bus.o_done      = (state == DONE);
    assign bus.o_err_imm   = err_imm;
    assign bus.o_err_full  = err_full;
    assign bus.o_state     = state;
endmodule

// File: tb/tb_z16_instr_encoder.sv
// Directed bench for z16_instr_encoder with a session-level reference model and write scoreboard.
module tb_z16_instr_encoder;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;
    localparam int BASE   = 60;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    z16_instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    z16_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a session is either open (accepting words) or not.
    bit              in_session;
    bit              finished;
    int              n_words;
    bit              e_imm;
    bit              e_full;
    bit              m_wen;
    logic [7:0]      m_addr;
    logic [15:0]     m_data;
    logic [23:0]     exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        int   sv;
        logic [15:0] w;
        if (!rst_n) begin
            in_session = 0; finished = 0; n_words = 0; e_imm = 0; e_full = 0;
            m_wen = 0; m_addr = '0; m_data = '0;
            exp_q.delete();
        end else begin
            m_wen = 0;
            if (!in_session) begin
                if (bus.i_start) begin
                    in_session = 1; finished = 0; n_words = 0; e_imm = 0; e_full = 0;
                end
            end else if (bus.i_valid && n_words < DEPTH) begin
                w = 16'(bus.i_opcode) + 16'(bus.i_rd_addr) * 16 + 16'(bus.i_rs1_addr) * 256
                  + 16'(bus.i_opcode == 4'hA ? bus.i_imm % 16 : 16'(bus.i_rs2_addr)) * 4096;
                m_addr = 8'((BASE + n_words) % 256);
                m_data = w;
                exp_q.push_back({m_addr, m_data});
                m_wen = 1;
                n_words++;
                sv = int'($signed(bus.i_imm));
                if (bus.i_opcode == 4'hA && (sv < -8 || sv > 7)) e_imm = 1;
                if (bus.i_last) begin
                    in_session = 0; finished = 1;
                end else if (n_words == DEPTH) begin
                    in_session = 0; finished = 1; e_full = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [23:0] e;
        check("ready", 32'(bus.o_ready), 32'(in_session && n_words < DEPTH));
        check("busy", 32'(bus.o_busy), 32'(in_session));
        check("done", 32'(bus.o_done), 32'(finished));
        check("count", 32'(bus.o_count), 32'(n_words));
        check("err_imm", 32'(bus.o_err_imm), 32'(e_imm));
        check("err_full", 32'(bus.o_err_full), 32'(e_full));
        check("wen", 32'(bus.o_mem_wen), 32'(m_wen));
        check("addr_hold", 32'(bus.o_mem_addr), 32'(m_addr));
        check("data_hold", 32'(bus.o_mem_wdata), 32'(m_data));
        if (bus.o_mem_wen) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(1), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.o_mem_addr), 32'(e[23:16]));
                check("wr_data", 32'(bus.o_mem_wdata), 32'(e[15:0]));
            end
        end else if (m_wen && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
        end
    end

    task automatic idle_inputs();
        bus.i_start = 0; bus.i_valid = 0; bus.i_opcode = 0; bus.i_rd_addr = 0;
        bus.i_rs1_addr = 0; bus.i_rs2_addr = 0; bus.i_imm = 0; bus.i_last = 0;
    endtask

    task automatic start_session();
        bus.i_start = 1;
        @(posedge clk); #1;
        bus.i_start = 0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one beat, waits (bounded) for o_ready, returns whether it was taken.
    task automatic beat(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                        input logic [3:0] rs2, input logic [15:0] imm, input logic last,
                        output bit acc);
        int k;
        bus.i_valid = 1; bus.i_opcode = op; bus.i_rd_addr = rd; bus.i_rs1_addr = rs1;
        bus.i_rs2_addr = rs2; bus.i_imm = imm; bus.i_last = last;
        k = 0;
        while (!bus.o_ready && k < 8) begin
            @(posedge clk); #1;
            k++;
        end
        acc = bus.o_ready;
        @(posedge clk); #1;
        bus.i_valid = 0; bus.i_last = 0;
    endtask

    initial begin
        bit acc;
        n_cmp = 0; n_bad = 0;
        rst_n = 0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.o_ready), 32'd0);
        check("rst_wen", 32'(bus.o_mem_wen), 32'd0);
        check("rst_addr", 32'(bus.o_mem_addr), 32'd0);
        check("rst_wdata", 32'(bus.o_mem_wdata), 32'd0);
        check("rst_count", 32'(bus.o_count), 32'd0);
        check("rst_flags", 32'({bus.o_busy, bus.o_done, bus.o_err_imm, bus.o_err_full}), 32'd0);
        rst_n = 1;
        gap(1);

        // Reset in the middle of a session drops the in-flight write.
        start_session();
        beat(4'h1, 4'h2, 4'h3, 4'h4, 16'h0, 1'b0, acc);
        check("mid_beat_acc", 32'(acc), 32'd1);
        check("mid_wen_before", 32'(bus.o_mem_wen), 32'd1);
        rst_n = 0;
        #1;
        check("mid_rst_wen", 32'(bus.o_mem_wen), 32'd0);
        check("mid_rst_count", 32'(bus.o_count), 32'd0);
        check("mid_rst_busy", 32'(bus.o_busy), 32'd0);
        check("mid_rst_data", 32'(bus.o_mem_wdata), 32'd0);
        @(posedge clk); #1;
        rst_n = 1;
        bus.i_valid = 1; bus.i_opcode = 4'h3;
        gap(3);
        check("nostart_ready", 32'(bus.o_ready), 32'd0);
        check("nostart_wen", 32'(bus.o_mem_wen), 32'd0);
        check("nostart_count", 32'(bus.o_count), 32'd0);
        bus.i_valid = 0;
        gap(1);

        // Single negative immediate that fits.
        start_session();
        check("start_busy", 32'(bus.o_busy), 32'd1);
        check("start_ready", 32'(bus.o_ready), 32'd1);
        beat(4'hA, 4'h3, 4'h0, 4'h0, 16'hFFFE, 1'b1, acc);
        check("one_acc", 32'(acc), 32'd1);
        check("one_wen", 32'(bus.o_mem_wen), 32'd1);
        check("one_addr", 32'(bus.o_mem_addr), 32'(BASE));
        check("one_wdata", 32'(bus.o_mem_wdata), 32'h0000E03A);
        check("one_done", 32'({bus.o_done, bus.o_busy, bus.o_ready}), 32'b100);
        check("one_count", 32'(bus.o_count), 32'd1);
        check("one_errs", 32'({bus.o_err_imm, bus.o_err_full}), 32'd0);
        gap(2);

        // Two beats with a valid gap.
        start_session();
        beat(4'h1, 4'h2, 4'h3, 4'h4, 16'h0, 1'b0, acc);
        check("two_w0", 32'({bus.o_mem_addr, bus.o_mem_wdata}), 32'({8'(BASE), 16'h4321}));
        gap(2);
        beat(4'hA, 4'h1, 4'h1, 4'h0, 16'h0007, 1'b1, acc);
        check("two_w1", 32'({bus.o_mem_addr, bus.o_mem_wdata}), 32'({8'(BASE + 1), 16'h711A}));
        check("two_errs", 32'({bus.o_err_imm, bus.o_done}), 32'b01);
        gap(1);

        // Out-of-range immediate: written truncated, sticky error; same imm on non-imm op is fine.
        start_session();
        beat(4'hA, 4'h0, 4'h0, 4'h0, 16'h0009, 1'b0, acc);
        check("imm_wdata", 32'(bus.o_mem_wdata), 32'h0000900A);
        check("imm_err", 32'(bus.o_err_imm), 32'd1);
        beat(4'h1, 4'h0, 4'h0, 4'h5, 16'h0009, 1'b0, acc);
        check("imm_op1_wdata", 32'(bus.o_mem_wdata), 32'h00005001);
        beat(4'hA, 4'h2, 4'h0, 4'h0, 16'hFFF7, 1'b1, acc);
        check("imm_neg9_wdata", 32'(bus.o_mem_wdata), 32'h0000702A);
        check("imm_sticky", 32'(bus.o_err_imm), 32'd1);
        gap(1);

        // Overflow: five beats, none last, only four land.
        start_session();
        check("restart_err_clear", 32'({bus.o_err_imm, bus.o_count}), 32'd0);
        for (int i = 0; i < 4; i++) begin
            beat(4'h2, 4'(i), 4'h1, 4'h0, 16'h0, 1'b0, acc);
            check("full_acc", 32'(acc), 32'd1);
        end
        check("full_addr", 32'(bus.o_mem_addr), 32'(BASE + 3));
        check("full_flags", 32'({bus.o_err_full, bus.o_done, bus.o_ready}), 32'b110);
        beat(4'h2, 4'h9, 4'h1, 4'h0, 16'h0, 1'b0, acc);
        check("full_fifth_rejected", 32'(acc), 32'd0);
        check("full_fifth_wen", 32'(bus.o_mem_wen), 32'd0);
        check("full_count", 32'(bus.o_count), 32'd4);

        // Restart from DONE, exact fill with last on the fourth beat.
        start_session();
        check("re_count", 32'(bus.o_count), 32'd0);
        check("re_errs", 32'({bus.o_err_imm, bus.o_err_full, bus.o_done}), 32'd0);
        for (int i = 0; i < 4; i++) begin
            beat(4'h5, 4'h1, 4'h2, 4'(i), 16'h0, 1'(i == 3), acc);
            if (i == 0) check("re_first_addr", 32'(bus.o_mem_addr), 32'(BASE));
        end
        check("exact_fill", 32'({bus.o_err_full, bus.o_done, bus.o_count}), 32'({1'b0, 1'b1, 9'd4}));
        gap(2);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
